// File: rtl/mem_pkg.sv
// Shared types and constants for the word-addressed memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    localparam logic [31:0] MEM_TEXT_BASE = 32'h00400000;
    localparam logic [31:0] MEM_ERR_DATA  = 32'hDEADBEEF;
    localparam int          CNT_W         = 4;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel between the CPU-side initiator and the memory responder.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_array.sv
// Word storage: synchronous byte-enabled write, combinational read, no reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= merge_bytes(mem[idx], wdata, be);
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Latency-configurable memory responder: one outstanding request, response held until accepted.
// The array is accessed on the edge that enters RESP; request inputs are ignored outside IDLE.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = MEM_TEXT_BASE,
    parameter int          LATENCY     = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    mem_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [3:0]       be_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;

    logic             live;
    logic             acc_we;
    logic [3:0]       acc_be;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic             acc_err;
    logic [IDX_W-1:0] acc_idx;
    logic             commit;
    logic             mem_we;
    logic [31:0]      mem_rdata;

    // With LATENCY==1 the access coincides with acceptance, so use the live request.
    assign live      = (state == IDLE);
    assign acc_we    = live ? bus.req_we    : we_q;
    assign acc_be    = live ? bus.req_be    : be_q;
    assign acc_addr  = live ? bus.req_addr  : addr_q;
    assign acc_wdata = live ? bus.req_wdata : wdata_q;

    assign acc_err = (acc_addr[1:0] != 2'b00)
                  || ({1'b0, acc_addr} <  {1'b0, BASE_ADDR})
                  || ({1'b0, acc_addr} >= END_ADDR);
    assign acc_idx = IDX_W'((acc_addr - BASE_ADDR) >> 2);

    // Gated by rst so a reset on the final WAIT edge drops the pending write.
    assign commit = rst && ((live && bus.req_valid && (LATENCY == 1))
                         || (state == WAIT && cnt == '0));
    assign mem_we = commit && acc_we && !acc_err;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (acc_be),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        be_q    <= bus.req_be;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        if (LATENCY == 1) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= acc_err;
                            rsp_rdata_q <= acc_err ? MEM_ERR_DATA : (acc_we ? '0 : mem_rdata);
                        end else begin
                            cnt   <= CNT_W'(LATENCY - 2);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= acc_err;
                        rsp_rdata_q <= acc_err ? MEM_ERR_DATA : (acc_we ? '0 : mem_rdata);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE) && rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
